// File: rtl/timer_ctrl.sv
// Programmable period timer: one-shot or periodic counting with hold, abort and
// rejected-start error reporting. All outputs are registered.
module timer_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [1:0]       state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_done;
    logic             r_busy;
    logic             r_err;
    logic [WIDTH-1:0] r_period_q;
    logic             r_mode_q;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tick_nxt;
    logic             w_err_nxt;
    logic [WIDTH-1:0] w_period_nxt;
    logic             w_mode_nxt;
    logic             w_period_ok;
    logic             w_terminal;

    assign w_period_ok = (period != '0);
    // period_q is never zero while counting, so the subtraction cannot underflow there.
    assign w_terminal  = (r_count == (r_period_q - WIDTH'(1)));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_tick_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_period_nxt = r_period_q;
        w_mode_nxt   = r_mode_q;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else if (start) begin
                    if (w_period_ok) begin
                        w_state_nxt  = S_RUN;
                        w_count_nxt  = '0;
                        w_period_nxt = period;
                        w_mode_nxt   = mode;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_err_nxt = start;
                    if (hold) begin
                        w_state_nxt = S_HOLD;
                    end else if (w_terminal) begin
                        w_count_nxt = '0;
                        w_tick_nxt  = 1'b1;
                        w_state_nxt = r_mode_q ? S_RUN : S_DONE;
                    end else begin
                        w_count_nxt = r_count + WIDTH'(1);
                    end
                end
            end

            S_HOLD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_err_nxt = start;
                    // Releasing hold only re-enters RUN; the count advances on the cycle after.
                    if (!hold) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_period_q <= '0;
            r_mode_q   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_tick     <= w_tick_nxt;
            r_done     <= (w_state_nxt == S_DONE);
            r_busy     <= (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
            r_err      <= w_err_nxt;
            r_period_q <= w_period_nxt;
            r_mode_q   <= w_mode_nxt;
        end
    end

    assign state = r_state;
    assign count = r_count;
    assign tick  = r_tick;
    assign done  = r_done;
    assign busy  = r_busy;
    assign err   = r_err;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_timer_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic         hold;
    logic         mode;
    logic [W-1:0] period;
    logic [W-1:0] count;
    logic         tick;
    logic         done;
    logic         busy;
    logic         err;
    logic [1:0]   state;

    int n_checks = 0;
    int n_errors = 0;

    timer_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .hold   (hold),
        .mode   (mode),
        .period (period),
        .count  (count),
        .tick   (tick),
        .done   (done),
        .busy   (busy),
        .err    (err),
        .state  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a sequence is either active (counting or frozen) or
    // not (idle or finished); the count advances modulo the latched period.
    bit m_valid = 0;
    bit m_active, m_frozen, m_finished, m_periodic, m_tick, m_err;
    int m_cnt, m_p;

    always @(posedge clk) begin
        m_tick = 0;
        m_err  = 0;
        if (rst) begin
            m_valid = 1; m_active = 0; m_frozen = 0; m_finished = 0;
            m_periodic = 0; m_cnt = 0; m_p = 0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 0; m_frozen = 0; m_cnt = 0;
            end else begin
                m_err = start;
                if (m_frozen)  m_frozen = hold;
                else if (hold) m_frozen = 1;
                else begin
                    m_cnt = (m_cnt + 1) % m_p;
                    if (m_cnt == 0) begin
                        m_tick = 1;
                        if (!m_periodic) begin
                            m_active = 0; m_finished = 1;
                        end
                    end
                end
            end
        end else begin
            if (abort) begin
                m_finished = 0;
            end else if (start) begin
                if (period != 0) begin
                    m_active = 1; m_finished = 0; m_cnt = 0;
                    m_p = int'(period); m_periodic = mode;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("mdl_count", count, m_cnt);
            check("mdl_tick",  tick,  m_tick);
            check("mdl_err",   err,   m_err);
            check("mdl_busy",  busy,  m_active);
            check("mdl_done",  done,  m_finished);
            check("mdl_state", state, m_active ? (m_frozen ? 2 : 1) : (m_finished ? 3 : 0));
        end
    end

    // Apply inputs for one rising edge; returns at the following falling edge.
    task automatic step(input bit s, input bit a, input bit h);
        start = s; abort = a; hold = h;
        @(negedge clk);
    endtask

    task automatic launch(input int p, input bit m);
        period = W'(p); mode = m;
        step(1, 0, 0);
        period = W'($urandom);
        mode   = 1'($urandom);
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; hold = 0; mode = 0; period = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_count", count, 0);
        check("rst_flags", {tick, done, busy, err}, 0);
        rst = 0;
        step(0, 0, 0);

        // Periodic P=4: 0,1,2,3,0,... with tick on every return to 0.
        launch(4, 1);
        check("p4_first_count", count, 0);
        check("p4_first_busy", busy, 1);
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 0);
            check("p4_count", count, i % 4);
            check("p4_tick", tick, (i % 4 == 0) ? 1 : 0);
            check("p4_busy", busy, 1);
        end
        step(0, 1, 0);
        check("p4_abort_state", state, 0);

        // One-shot P=3, then relaunch from DONE.
        launch(3, 0);
        check("os_c0", count, 0);
        step(0, 0, 0); check("os_c1", count, 1);
        step(0, 0, 0); check("os_c2", count, 2);
        step(0, 0, 0);
        check("os_end_tick", tick, 1);
        check("os_end_state", state, 3);
        check("os_end_done_busy", {done, busy}, 2'b10);
        check("os_end_count", count, 0);
        step(0, 0, 0);
        check("os_stay_tick", tick, 0);
        check("os_stay_state", state, 3);
        launch(2, 0);
        check("os_relaunch_state", state, 1);
        check("os_relaunch_done", done, 0);
        step(0, 0, 0); check("os_rl_c1", count, 1);
        step(0, 0, 0); check("os_rl_state", state, 3);
        step(0, 1, 0); check("os_abort_state", state, 0);

        // Hold at count 2 of P=6 for three cycles, then resume.
        launch(6, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        check("hold_pre_count", count, 2);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            check("hold_state", state, 2);
            check("hold_count", count, 2);
            check("hold_busy", busy, 1);
        end
        step(0, 0, 0);
        check("hold_release_state", state, 1);
        check("hold_release_count", count, 2);
        step(0, 0, 0); check("hold_c3", count, 3);
        step(0, 0, 0); check("hold_c4", count, 4);
        step(0, 0, 0); check("hold_c5", count, 5);
        step(0, 0, 0);
        check("hold_c0", count, 0);
        check("hold_tick", tick, 1);
        step(0, 1, 0);

        // Rejected starts.
        period = '0;
        step(1, 0, 0);
        check("zero_err", err, 1);
        check("zero_state", state, 0);
        step(0, 0, 0);
        check("zero_err_clear", err, 0);
        launch(4, 1);
        step(0, 0, 0); check("busy_start_c1", count, 1);
        step(1, 0, 0);
        check("busy_start_err", err, 1);
        check("busy_start_count", count, 2);
        step(0, 0, 0);
        check("busy_start_c3", count, 3);
        check("busy_start_err_clear", err, 0);
        step(0, 1, 0);

        // Abort with hold at the terminal count, then reset mid-run.
        launch(6, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        check("ab_pre_count", count, 5);
        step(0, 1, 1);
        check("ab_state", state, 0);
        check("ab_count", count, 0);
        check("ab_tick", tick, 0);
        launch(6, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1;
        step(1, 0, 1);
        check("mid_rst_state", state, 0);
        check("mid_rst_outs", {count, tick, done, busy, err}, 0);
        rst = 0;

        // P=1 periodic: count pinned at 0, tick every cycle after the first.
        launch(1, 1);
        check("p1_first_tick", tick, 0);
        check("p1_first_count", count, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            check("p1_count", count, 0);
            check("p1_tick", tick, 1);
        end
        step(0, 1, 0);
        check("p1_abort_tick", tick, 0);
        check("p1_abort_state", state, 0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            start  = ($urandom_range(0, 5) == 0);
            abort  = ($urandom_range(0, 24) == 0);
            hold   = ($urandom_range(0, 4) == 0);
            mode   = 1'($urandom);
            period = ($urandom_range(0, 4) == 0) ? W'($urandom) : W'($urandom_range(0, 9));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
